// File: rtl/pipe_control.sv
// Pipeline controller for the 5-stage Y86-64 core: hazard detection, stall/bubble
// generation, fetch PC register, run/halt FSM and performance counters.
module pipe_control #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [63:0]      f_predPC,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic [63:0]      F_predPC,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic [1:0]       state,
    output logic [2:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POP    = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic lu;
    logic rt;
    logic mp;
    logic exc_m;
    logic exc_w;

    assign lu = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                (E_dstM != REG_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_Cnd;

    assign exc_m = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign exc_w = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);

    assign state = cur_state;

    // Pipeline controls depend on the FSM state; IDLE flushes, HALTED freezes.
    always_comb begin
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        W_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        next_state = cur_state;
        case (cur_state)
            RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (!lu & rt);
                E_bubble = mp | lu;
                M_bubble = exc_m | exc_w;
                W_stall  = exc_w;
                if (exc_w) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (go) begin
                    next_state = RUN;
                end
            end
        endcase
    end

    // Fetch PC, final status and counters only advance while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            F_predPC   <= RESET_PC;
            cpu_stat   <= S_AOK;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == RUN) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
                if ((W_stat == S_AOK) && (W_icode != I_NOP)) begin
                    retire_cnt <= retire_cnt + CNT_ONE;
                end
                if (F_stall) begin
                    stall_cnt <= stall_cnt + CNT_ONE;
                end else begin
                    F_predPC <= f_predPC;
                end
                if (exc_w) begin
                    cpu_stat <= W_stat;
                end
            end
        end
    end

endmodule
